// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder -- bit-serial WIDTH-bit unsigned adder.
//
// Two operands and a carry-in are captured on an accepted start request. One
// bit pair per clock (LSB first) is fed through a single one-bit full-adder
// cell. The cell's carry-out is registered and becomes the next cycle's
// carry-in. Sum bits are shifted into an accumulator. When the last bit has
// been processed, the completed sum and carry-out are loaded into the result
// registers and a one-cycle done pulse is raised.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      begin an addition (accepted in IDLE or DONE)
//   A      in   WIDTH  operand A, captured on an accepted start
//   B      in   WIDTH  operand B, captured on an accepted start
//   Ci     in   1      carry-in, captured on an accepted start
//   busy   out  1      high while bits are being processed
//   done   out  1      one-cycle pulse; S/Co hold a new result
//   S      out  WIDTH  registered sum, held until the next result
//   Co     out  1      registered carry-out of the MSB, held with S
// -----------------------------------------------------------------------------

// One-bit full-adder cell: sum and majority carry.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// Protocol checks on the sequencer status outputs.
module serial_adder_chk (
  input logic clk,
  input logic rst_n,
  input logic busy,
  input logic done
);
  // busy and done are decoded from distinct states and never overlap.
  a_busy_done_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(busy && done));

  // done is a single-cycle pulse.
  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Co
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;

  logic [WIDTH-1:0] sha_r;
  logic [WIDTH-1:0] shb_r;
  logic             cy_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] sum_r;
  logic             co_r;
  logic             busy_r;
  logic             done_r;

  logic             fa_s_s;
  logic             fa_co_s;
  logic             accept_s;
  logic             last_s;
  logic [WIDTH-1:0] acc_nxt_s;

  // The cell sees only register outputs, so its inputs are glitch-free.
  full_adder u_fa (
    .a  (sha_r[0]),
    .b  (shb_r[0]),
    .ci (cy_r),
    .s  (fa_s_s),
    .co (fa_co_s)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at acc[0].
  // The size cast keeps this valid for WIDTH == 1.
  assign acc_nxt_s = WIDTH'({fa_s_s, acc_r} >> 1'b1);

  // Next-state decode plus the accept/last-bit strobes used by the datapath.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cnt_r == LAST_CNT) begin
          last_s      = 1'b1;
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: begin
        // A start here is accepted immediately for back-to-back operation.
        if (start) begin
          accept_s    = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and status flags; flags track the state being entered so
  // that they equal a decode of the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_RUN);
      done_r  <= (state_nxt_s == ST_DONE);
    end
  end

  // Operand capture, bit-serial shifting, carry chaining and result load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sha_r <= {WIDTH{1'b0}};
      shb_r <= {WIDTH{1'b0}};
      cy_r  <= 1'b0;
      acc_r <= {WIDTH{1'b0}};
      cnt_r <= {CW{1'b0}};
      sum_r <= {WIDTH{1'b0}};
      co_r  <= 1'b0;
    end else begin
      if (accept_s) begin
        sha_r <= A;
        shb_r <= B;
        cy_r  <= Ci;
        cnt_r <= {CW{1'b0}};
      end else if (state_r == ST_RUN) begin
        sha_r <= sha_r >> 1'b1;
        shb_r <= shb_r >> 1'b1;
        acc_r <= acc_nxt_s;
        cy_r  <= fa_co_s;
        cnt_r <= cnt_r + CNT_ONE;
        if (last_s) begin
          sum_r <= acc_nxt_s;
          co_r  <= fa_co_s;
        end else begin
          sum_r <= sum_r;
          co_r  <= co_r;
        end
      end else begin
        sha_r <= sha_r;
        shb_r <= shb_r;
        cy_r  <= cy_r;
        acc_r <= acc_r;
        cnt_r <= cnt_r;
      end
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign S    = sum_r;
  assign Co   = co_r;

  serial_adder_chk u_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .busy  (busy_r),
    .done  (done_r)
  );

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder -- directed self-checking bench for serial_adder.
// Instantiates a WIDTH=8 and a WIDTH=1 adder on a shared clock and reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       start8;
  logic [7:0] a8;
  logic [7:0] b8;
  logic       ci8;
  logic       busy8;
  logic       done8;
  logic [7:0] s8;
  logic       co8;

  logic       start1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       ci1;
  logic       busy1;
  logic       done1;
  logic [0:0] s1;
  logic       co1;

  int checks;
  int failures;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .A     (a8),
    .B     (b8),
    .Ci    (ci8),
    .busy  (busy8),
    .done  (done8),
    .S     (s8),
    .Co    (co8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start1),
    .A     (a1),
    .B     (b1),
    .Ci    (ci1),
    .busy  (busy1),
    .done  (done1),
    .S     (s1),
    .Co    (co1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one WIDTH=8 addition from a falling edge and observe 12 cycles.
  // Index i is the cycle following edge k+i (k = accepting edge).
  // inject >= 0 pulses start with A=B=1 so that it is sampled on edge k+inject.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic ci,
                      input int inject,
                      output int busy_n, output int done_n, output int done_idx,
                      output logic [7:0] s, output logic co);
    busy_n   = 0;
    done_n   = 0;
    done_idx = -1;
    s        = 8'h00;
    co       = 1'b0;
    a8 = a; b8 = b; ci8 = ci; start8 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start8 = 1'b0;
        a8 = 8'hEE; b8 = 8'hEE; ci8 = 1'b1;
      end
      if (busy8) busy_n++;
      if (done8) begin
        done_n++;
        done_idx = i;
        s  = s8;
        co = co8;
      end
      if (inject >= 0 && i == inject - 1) begin
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; ci8 = 1'b0;
      end
      if (inject >= 0 && i == inject) start8 = 1'b0;
    end
  endtask

  initial begin
    int          bn;
    int          dn;
    int          di;
    logic [7:0]  rs;
    logic        rc;
    int          holds;
    logic [1:0]  sum1;

    checks   = 0;
    failures = 0;
    rst_n  = 1'b0;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; ci8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0;  b1 = 1'b0;  ci1 = 1'b0;

    // Reset state
    #12;
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_s8",    32'(s8),    32'd0);
    chk("rst_co8",   32'(co8),   32'd0);
    chk("rst_busy1", 32'(busy1), 32'd0);
    chk("rst_done1", 32'(done1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic add: 0x5A + 0x33 = 0x8D
    run8(8'h5A, 8'h33, 1'b0, -1, bn, dn, di, rs, rc);
    chk("basic_busy_cycles", 32'(bn), 32'd8);
    chk("basic_done_count",  32'(dn), 32'd1);
    chk("basic_done_index",  32'(di), 32'd8);
    chk("basic_s",           32'(rs), 32'h8D);
    chk("basic_co",          32'(rc), 32'd0);
    chk("basic_s_hold",      32'(s8), 32'h8D);

    // Full carry ripple: 0xFF + 0x01 = 0x100
    run8(8'hFF, 8'h01, 1'b0, -1, bn, dn, di, rs, rc);
    chk("ripple1_done_index", 32'(di), 32'd8);
    chk("ripple1_s",          32'(rs), 32'h00);
    chk("ripple1_co",         32'(rc), 32'd1);

    // 0xFF + 0xFF + 1 = 0x1FF
    run8(8'hFF, 8'hFF, 1'b1, -1, bn, dn, di, rs, rc);
    chk("ripple2_s",  32'(rs), 32'hFF);
    chk("ripple2_co", 32'(rc), 32'd1);

    // Start during busy at edge 3 must be ignored
    run8(8'h5A, 8'h33, 1'b0, 3, bn, dn, di, rs, rc);
    chk("busystart_done_count", 32'(dn), 32'd1);
    chk("busystart_done_index", 32'(di), 32'd8);
    chk("busystart_s",          32'(rs), 32'h8D);
    chk("busystart_co",         32'(rc), 32'd0);

    // Back-to-back with start held high: 0x10+0x20 then 0x80+0x80
    holds = 0;
    dn    = 0;
    a8 = 8'h10; b8 = 8'h20; ci8 = 1'b0; start8 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done8) dn++;
      if (i == 8) begin
        chk("b2b_first_done", 32'(done8), 32'd1);
        chk("b2b_first_s",    32'(s8),    32'h30);
        chk("b2b_first_co",   32'(co8),   32'd0);
        a8 = 8'h80; b8 = 8'h80;
      end
      if (i == 9) start8 = 1'b0;
      if (i > 8 && i < 17 && s8 == 8'h30 && co8 == 1'b0) holds++;
      if (i == 17) begin
        chk("b2b_second_done", 32'(done8), 32'd1);
        chk("b2b_second_s",    32'(s8),    32'h00);
        chk("b2b_second_co",   32'(co8),   32'd1);
      end
    end
    chk("b2b_s_hold_cycles", 32'(holds), 32'd8);
    chk("b2b_done_count",    32'(dn),    32'd2);

    // Asynchronous reset during RUN cycle 4 aborts the operation
    a8 = 8'h5A; b8 = 8'h33; ci8 = 1'b0; start8 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) start8 = 1'b0;
    end
    chk("abort_busy_before", 32'(busy8), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy_now", 32'(busy8), 32'd0);
    chk("abort_s_now",    32'(s8),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done8) dn++;
    end
    chk("abort_no_done", 32'(dn),  32'd0);
    chk("abort_s",       32'(s8),  32'd0);
    chk("abort_co",      32'(co8), 32'd0);

    run8(8'h5A, 8'h33, 1'b0, -1, bn, dn, di, rs, rc);
    chk("post_abort_done_index", 32'(di), 32'd8);
    chk("post_abort_s",          32'(rs), 32'h8D);
    chk("post_abort_co",         32'(rc), 32'd0);

    // WIDTH=1: all eight operand combinations
    for (int c = 0; c < 8; c++) begin
      a1 = c[2]; b1 = c[1]; ci1 = c[0];
      sum1 = 2'(c[2]) + 2'(c[1]) + 2'(c[0]);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      a1 = ~a1; b1 = ~b1; ci1 = ~ci1;
      chk($sformatf("w1_busy_%0d", c), 32'(busy1), 32'd1);
      chk($sformatf("w1_early_done_%0d", c), 32'(done1), 32'd0);
      @(negedge clk);
      chk($sformatf("w1_done_%0d", c), 32'(done1), 32'd1);
      chk($sformatf("w1_sum_%0d", c), 32'({co1, s1}), 32'(sum1));
      @(negedge clk);
      chk($sformatf("w1_done_drop_%0d", c), 32'(done1), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial N-bit adder built around the team's existing one-bit full-adder cell (FA: S = A^B^Ci, Co = majority(A,B,Ci)). It latches two operands and a carry-in on a start request, feeds one bit pair per clock (LSB first) into a single FA instance, and registers the FA carry-out as the next cycle's carry-in. It collects the sum bits and presents the completed sum and carry-out with a one-cycle done pulse. It is the sequencing stage directly upstream and downstream of the FA cell: it drives the cell's inputs and consumes its outputs.

## Interface
- WIDTH, 8: operand and sum width in bits; legal range ≥ 1.
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request to begin an addition; sampled on rising clk.
- A  input  WIDTH  operand A; sampled only on an accepted start.
- B  input  WIDTH  operand B; sampled only on an accepted start.
- Ci  input  1  carry-in; sampled only on an accepted start.
- busy  output  1  high while bits are being processed (RUN state).
- done  output  1  one-cycle pulse; S and Co are valid and new.
- S  output  WIDTH  registered sum result; holds until the next result.
- Co  output  1  registered carry-out of the MSB; holds with S.

## Operation
- Internal state:
  - shA, shB: WIDTH-bit shift registers.
  - cy: 1-bit carry register.
  - acc: WIDTH-bit sum shift register.
  - cnt: $clog2(WIDTH+1) bits.
  - FSM with states IDLE, RUN, DONE.
- The FA instance inputs are A=shA[0], B=shB[0], Ci=cy. They are purely combinational off registers.
- IDLE, when start=1:
  - shA<=A, shB<=B, cy<=Ci, cnt<=0, acc unchanged.
  - Next state RUN.
  - If start=0, stay in IDLE.
- RUN, every cycle:
  - shA, shB shift right by 1.
  - acc<={FA.S, acc[WIDTH-1:1]}.
  - cy<=FA.Co.
  - cnt<=cnt+1.
  - When cnt==WIDTH-1, also load S<={FA.S, acc[WIDTH-1:1]} and Co<=FA.Co, then go to DONE.
  - start is ignored in RUN.
- DONE:
  - done=1 for exactly this cycle.
  - If start=1, accept it exactly as in IDLE (back-to-back operation) and go to RUN.
  - Otherwise go to IDLE.
- Arithmetic: {Co,S} = A + B + Ci, modulo 2^(WIDTH+1), unsigned. No overflow flag is produced.
- busy=1 iff state==RUN. done=1 iff state==DONE. Both are decoded from registered state, so they are glitch-free.
- S and Co change only on the final RUN edge. Between results they hold the last value.

## Timing
- Reset (rst_n=0, takes effect immediately):
  - state=IDLE; busy=0, done=0, S=0, Co=0.
  - shA=shB=acc=0, cy=0, cnt=0.
- Reset mid-RUN aborts the operation. No done pulse is produced, and S/Co read 0.
- Latency: start is accepted at edge k. Edges k+1 through k+WIDTH process the bits.
  - busy is high from after edge k until edge k+WIDTH.
  - done, S and Co are valid in the cycle following edge k+WIDTH.
  - done falls at edge k+WIDTH+1.
- Throughput: one addition per WIDTH+1 cycles with start held high continuously.
- Operand inputs may change freely after the accepting edge.
- WIDTH=1: a single RUN cycle; done appears 2 edges after start.

## Test plan
- Basic add, WIDTH=8: A=0x5A, B=0x33, Ci=0, start pulsed at edge 0.
  - Required: busy high for 8 cycles; done high after edge 8 only; S=0x8D, Co=0.
- Carry ripple across all bits, WIDTH=8:
  - A=0xFF, B=0x01, Ci=0 → S=0x00, Co=1.
  - A=0xFF, B=0xFF, Ci=1 → S=0xFF, Co=1.
- Start during busy: start the first add (0x5A+0x33), then pulse start with A=0x01, B=0x01 at edge 3.
  - Required: ignored; result S=0x8D, done once.
- Back-to-back: hold start high with A=0x10, B=0x20, then in the DONE cycle present A=0x80, B=0x80.
  - Required: first done gives S=0x30, Co=0.
  - Required: second done 9 cycles later gives S=0x00, Co=1.
  - Required: S holds 0x30 until the second result.
- Reset mid-operation: assert rst_n=0 asynchronously during RUN cycle 4, release, and wait 12 cycles.
  - Required: busy drops immediately; no done pulse; S=0, Co=0.
  - Required: a subsequent 0x5A+0x33 completes correctly.
- WIDTH=1 instance: all 8 combinations of A, B, Ci.
  - Required: {Co,S} = A+B+Ci; done 2 edges after start.
